// File: rtl/canny_pkg.sv
// ----------------------------------------------------------------------------
// canny_pkg
//   Shared types and constants for the Canny frame sequencer.
//   - canny_ctrl_st_t : controller FSM states
//   - FRAME_CNT_W     : width of the completed-frame counter
//   - cnt_width()     : counter width for a modulus n, never narrower than 1 bit
// ----------------------------------------------------------------------------
package canny_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      STREAM   = 3'd1,
      GAP      = 3'd2,
      WAIT_RES = 3'd3,
      DONE     = 3'd4
   } canny_ctrl_st_t;

   localparam int FRAME_CNT_W = 16;

   // $clog2(1) is 0, so a modulus of 1 still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/raster_cnt.sv
// ----------------------------------------------------------------------------
// raster_cnt
//   Column/row position of the next pixel to be accepted, and the raster
//   flags derived from it.
// Ports
//   clk_i   in  clock
//   rst_ni  in  asynchronous active-low reset
//   clr_i   in  return to column 0 / row 0 (frame cancelled)
//   adv_i   in  one pixel consumed: advance the position
//   sol_o   out current position is the first column
//   eol_o   out current position is the last column
//   sof_o   out current position is the first pixel of the frame
//   eof_o   out current position is the last pixel of the frame
// ----------------------------------------------------------------------------
module raster_cnt
   import canny_pkg::*;
#(
   parameter int W = 640,
   parameter int H = 480
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic adv_i,
   output logic sol_o,
   output logic eol_o,
   output logic sof_o,
   output logic eof_o
);

   localparam int CW = cnt_width(W);
   localparam int RW = cnt_width(H);
   localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          last_col, last_row;

   assign last_col = (col_q == COL_LAST);
   assign last_row = (row_q == ROW_LAST);

   assign sol_o = (col_q == '0);
   assign eol_o = last_col;
   assign sof_o = (col_q == '0) && (row_q == '0);
   assign eof_o = last_col && last_row;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (adv_i) begin
         if (last_col) begin
            col_d = '0;
            // Wrapping the row on the last pixel leaves the counter ready for the next frame.
            row_d = last_row ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/canny_frame_ctrl.sv
// ----------------------------------------------------------------------------
// canny_frame_ctrl
//   Frame sequencer in front of the Canny pipeline. After a start request it
//   takes FRAME_WIDTH x FRAME_HEIGHT RGB pixels from a valid/ready source,
//   forwards them one cycle later with SOF/EOF/SOL/EOL markers, idles
//   LINE_GAP cycles after every line, then waits for the pipeline result.
// Ports
//   clk_i          in  clock
//   rst_ni         in  asynchronous active-low reset
//   start_i        in  one-cycle request to process a frame (ignored while busy)
//   abort_i        in  cancel the current frame, highest priority
//   src_val_i      in  source pixel valid
//   src_rdy_o      out controller ready for a source pixel (combinational)
//   src_data_i     in  source RGB pixel
//   pix_val_o      out pipeline pixel valid
//   pix_sof_o      out first pixel of frame
//   pix_eof_o      out last pixel of frame
//   pix_sol_o      out first pixel of line
//   pix_eol_o      out last pixel of line
//   pix_data_o     out pipeline pixel data (holds between beats)
//   canny_val_i    in  pipeline result valid
//   busy_o         out controller not idle
//   done_o         out one-cycle pulse: result frame valid
//   timeout_err_o  out one-cycle pulse: no result within TIMEOUT_CYC cycles
//   frame_cnt_o    out completed frames, wrapping
// ----------------------------------------------------------------------------
module canny_frame_ctrl
   import canny_pkg::*;
#(
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int PIX_WIDTH    = 24,
   parameter int LINE_GAP     = 4,
   parameter int TIMEOUT_CYC  = 1048576
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic                   src_val_i,
   output logic                   src_rdy_o,
   input  logic [PIX_WIDTH-1:0]   src_data_i,
   output logic                   pix_val_o,
   output logic                   pix_sof_o,
   output logic                   pix_eof_o,
   output logic                   pix_sol_o,
   output logic                   pix_eol_o,
   output logic [PIX_WIDTH-1:0]   pix_data_o,
   input  logic                   canny_val_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   timeout_err_o,
   output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

   localparam int GW = cnt_width(LINE_GAP);
   localparam int TW = cnt_width(TIMEOUT_CYC);
   localparam logic [GW-1:0] GAP_LAST = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   canny_ctrl_st_t         state_q, state_d;
   logic [GW-1:0]          gap_q, gap_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic                   done_q, done_d;
   logic                   tmo_err_q, tmo_err_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic                   pix_val_q, pix_sof_q, pix_eof_q, pix_sol_q, pix_eol_q;
   logic [PIX_WIDTH-1:0]   pix_data_q;

   logic accept;
   logic beat;
   logic r_sol, r_eol, r_sof, r_eof;

   assign src_rdy_o = (state_q == STREAM);
   assign accept    = src_val_i && src_rdy_o;
   // A pixel handed over in the same cycle as an abort is dropped, not forwarded.
   assign beat      = accept && !abort_i;

   raster_cnt #(
      .W (FRAME_WIDTH),
      .H (FRAME_HEIGHT)
   ) u_raster (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (abort_i),
      .adv_i  (beat),
      .sol_o  (r_sol),
      .eol_o  (r_eol),
      .sof_o  (r_sof),
      .eof_o  (r_eof)
   );

   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      tmo_d       = tmo_q;
      done_d      = 1'b0;
      tmo_err_d   = 1'b0;
      frame_cnt_d = frame_cnt_q;
      if (abort_i) begin
         state_d = IDLE;
         gap_d   = '0;
         tmo_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) state_d = STREAM;
            end
            STREAM: begin
               if (accept && r_eof) begin
                  state_d = WAIT_RES;
               end else if (accept && r_eol && (LINE_GAP > 0)) begin
                  state_d = GAP;
                  gap_d   = '0;
               end
            end
            GAP: begin
               if (gap_q == GAP_LAST) begin
                  state_d = STREAM;
                  gap_d   = '0;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            WAIT_RES: begin
               // A result arriving on the final timeout cycle still counts as success.
               if (canny_val_i) begin
                  state_d     = DONE;
                  tmo_d       = '0;
                  done_d      = 1'b1;
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end else if (tmo_q == TMO_LAST) begin
                  state_d   = IDLE;
                  tmo_d     = '0;
                  tmo_err_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         gap_q       <= '0;
         tmo_q       <= '0;
         done_q      <= 1'b0;
         tmo_err_q   <= 1'b0;
         frame_cnt_q <= '0;
         pix_val_q   <= 1'b0;
         pix_sof_q   <= 1'b0;
         pix_eof_q   <= 1'b0;
         pix_sol_q   <= 1'b0;
         pix_eol_q   <= 1'b0;
         pix_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         tmo_q       <= tmo_d;
         done_q      <= done_d;
         tmo_err_q   <= tmo_err_d;
         frame_cnt_q <= frame_cnt_d;
         pix_val_q   <= beat;
         pix_sof_q   <= beat && r_sof;
         pix_eof_q   <= beat && r_eof;
         pix_sol_q   <= beat && r_sol;
         pix_eol_q   <= beat && r_eol;
         if (beat) pix_data_q <= src_data_i;
      end
   end

   assign pix_val_o     = pix_val_q;
   assign pix_sof_o     = pix_sof_q;
   assign pix_eof_o     = pix_eof_q;
   assign pix_sol_o     = pix_sol_q;
   assign pix_eol_o     = pix_eol_q;
   assign pix_data_o    = pix_data_q;
   assign busy_o        = (state_q != IDLE);
   assign done_o        = done_q;
   assign timeout_err_o = tmo_err_q;
   assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
module tb_canny_frame_ctrl;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int N    = W * H;
   localparam int GAPC = 2;
   localparam int TMO  = 16;
   localparam int PW   = 24;
   localparam int NCYC = 17;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // DUT A: 4x3 frame, 2-cycle line gap, 16-cycle timeout
   logic          a_start, a_abort, a_src_val, a_src_rdy, a_canny;
   logic [PW-1:0] a_src_data, a_pix_data;
   logic          a_pix_val, a_pix_sof, a_pix_eof, a_pix_sol, a_pix_eol;
   logic          a_busy, a_done, a_tmo;
   logic [15:0]   a_frame_cnt;

   // DUT B: 1x1 frame, no line gap
   logic          b_start, b_abort, b_src_val, b_src_rdy, b_canny;
   logic [PW-1:0] b_src_data, b_pix_data;
   logic          b_pix_val, b_pix_sof, b_pix_eof, b_pix_sol, b_pix_eol;
   logic          b_busy, b_done, b_tmo;
   logic [15:0]   b_frame_cnt;

   canny_frame_ctrl #(
      .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIX_WIDTH(PW), .LINE_GAP(GAPC), .TIMEOUT_CYC(TMO)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .abort_i(a_abort),
      .src_val_i(a_src_val), .src_rdy_o(a_src_rdy), .src_data_i(a_src_data),
      .pix_val_o(a_pix_val), .pix_sof_o(a_pix_sof), .pix_eof_o(a_pix_eof),
      .pix_sol_o(a_pix_sol), .pix_eol_o(a_pix_eol), .pix_data_o(a_pix_data),
      .canny_val_i(a_canny), .busy_o(a_busy), .done_o(a_done),
      .timeout_err_o(a_tmo), .frame_cnt_o(a_frame_cnt)
   );

   canny_frame_ctrl #(
      .FRAME_WIDTH(1), .FRAME_HEIGHT(1), .PIX_WIDTH(PW), .LINE_GAP(0), .TIMEOUT_CYC(TMO)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .abort_i(b_abort),
      .src_val_i(b_src_val), .src_rdy_o(b_src_rdy), .src_data_i(b_src_data),
      .pix_val_o(b_pix_val), .pix_sof_o(b_pix_sof), .pix_eof_o(b_pix_eof),
      .pix_sol_o(b_pix_sol), .pix_eol_o(b_pix_eol), .pix_data_o(b_pix_data),
      .canny_val_i(b_canny), .busy_o(b_busy), .done_o(b_done),
      .timeout_err_o(b_tmo), .frame_cnt_o(b_frame_cnt)
   );

   int total = 0;
   int bad   = 0;

   // One row per cycle after the start edge: input src_val, expected src_rdy,
   // pix_val and markers {sof,eof,sol,eol}.
   typedef struct packed {
      logic       src_val;
      logic       rdy;
      logic       val;
      logic [3:0] mk;
   } vec_t;
   vec_t tbl[NCYC];

   logic [PW-1:0] sent[N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Streams one frame into DUT A with random bubbles. Expected behaviour is
   // derived from the pixel index: column k%W, row k/W, a gap of GAPC cycles
   // after every line except the last. abort_at >= 0 cancels the frame when
   // that many pixels have been handed over.
   task automatic run_frame(input int pbub, input int abort_at, input bit rand_ctl);
      int k_acc, k_out, cyc, gap_left;
      bit acc, exp_rdy;
      k_acc = 0; k_out = 0; cyc = 0; gap_left = 0;
      for (int i = 0; i < N; i++) sent[i] = PW'($urandom);
      while (1) begin
         if (a_pix_val) begin
            if (k_out < N) begin
               chk("pix_data", a_pix_data, sent[k_out]);
               chk("pix_sof", a_pix_sof, k_out == 0);
               chk("pix_eof", a_pix_eof, k_out == N - 1);
               chk("pix_sol", a_pix_sol, (k_out % W) == 0);
               chk("pix_eol", a_pix_eol, (k_out % W) == W - 1);
            end else begin
               chk("extra_beat", k_out, N - 1);
            end
            k_out++;
         end else begin
            chk("idle_markers", {a_pix_sof, a_pix_eof, a_pix_sol, a_pix_eol}, 4'b0);
         end
         if (k_out >= N) break;
         if (abort_at >= 0 && k_acc == abort_at) begin
            a_abort = 1'b1; a_src_val = 1'b1; a_src_data = sent[k_acc];
            step();
            a_abort = 1'b0; a_src_val = 1'b0;
            $display("frame aborted after %0d pixels", k_acc);
            return;
         end
         exp_rdy = (k_acc < N) && (gap_left == 0);
         chk("src_rdy", a_src_rdy, exp_rdy);
         a_src_val  = (k_acc < N) && ($urandom_range(0, 99) >= pbub);
         a_src_data = (k_acc < N) ? sent[k_acc] : PW'($urandom);
         if (rand_ctl && k_acc < N) begin
            a_start = ($urandom_range(0, 3) == 0);
            a_canny = ($urandom_range(0, 3) == 0);
         end
         acc = a_src_val && exp_rdy;
         step();
         cyc++;
         a_start = 1'b0; a_canny = 1'b0; a_src_val = 1'b0;
         if (gap_left > 0) gap_left--;
         if (acc) begin
            k_acc++;
            if ((k_acc % W) == 0 && k_acc < N && GAPC > 0) gap_left = GAPC;
         end
         if (cyc > 2000) begin
            chk("frame_budget", cyc, 0);
            return;
         end
      end
      $display("frame streamed: %0d beats in %0d cycles", k_out, cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int nacc, nbeat;
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'b0000};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'b1010};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 4'b0000};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'b0000};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 4'b0001};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'b0000};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'b0000};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'b0010};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'b0000};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'b0000};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 4'b0001};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 4'b0000};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 4'b0000};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 4'b0010};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 4'b0000};
      tbl[15] = '{1'b1, 1'b1, 1'b1, 4'b0000};
      tbl[16] = '{1'b1, 1'b0, 1'b1, 4'b0101};

      a_start = 0; a_abort = 0; a_src_val = 0; a_src_data = '0; a_canny = 0;
      b_start = 0; b_abort = 0; b_src_val = 0; b_src_data = '0; b_canny = 0;
      rst_n = 1'b0;
      #12;
      chk("reset_outputs", {a_src_rdy, a_pix_val, a_pix_sof, a_pix_eof, a_pix_sol,
                            a_pix_eol, a_busy, a_done, a_tmo}, 9'b0);
      chk("reset_frame_cnt", a_frame_cnt, 16'd0);
      chk("reset_pix_data", a_pix_data, 24'd0);
      rst_n = 1'b1;
      step();

      // Continuous stream, cycle-exact against the table
      a_start = 1'b1; step(); a_start = 1'b0;
      nacc = 0; nbeat = 0;
      for (int c = 0; c < NCYC; c++) begin
         chk($sformatf("t%0d_src_rdy", c), a_src_rdy, tbl[c].rdy);
         chk($sformatf("t%0d_pix_val", c), a_pix_val, tbl[c].val);
         chk($sformatf("t%0d_markers", c), {a_pix_sof, a_pix_eof, a_pix_sol, a_pix_eol}, tbl[c].mk);
         if (tbl[c].val) begin
            chk($sformatf("t%0d_pix_data", c), a_pix_data, 24'h100 + nbeat);
            nbeat++;
         end
         a_src_val  = tbl[c].src_val;
         a_src_data = PW'(24'h100 + nacc);
         if (tbl[c].src_val && tbl[c].rdy) nacc++;
         step();
      end
      a_src_val = 1'b0;
      $display("table frame: %0d beats", nbeat);

      // Result 10 cycles after EOF -> done one cycle later
      for (int i = 0; i < 9; i++) begin
         chk("wait_no_done", a_done, 1'b0);
         chk("wait_busy", a_busy, 1'b1);
         step();
      end
      a_canny = 1'b1; step(); a_canny = 1'b0;
      chk("done_pulse", a_done, 1'b1);
      chk("done_frame_cnt", a_frame_cnt, 16'd1);
      chk("done_busy", a_busy, 1'b1);
      step();
      chk("done_one_cycle", a_done, 1'b0);
      chk("idle_after_done", a_busy, 1'b0);
      $display("frame done: frame_cnt=%0d", a_frame_cnt);

      // Random bubbles, stray start/canny_val while streaming, then timeout
      a_start = 1'b1; step(); a_start = 1'b0;
      run_frame(50, -1, 1'b1);
      chk("wait_res_busy", a_busy, 1'b1);
      chk("wait_res_rdy", a_src_rdy, 1'b0);
      chk("stale_canny_ignored", a_frame_cnt, 16'd1);
      for (int i = 1; i <= TMO; i++) begin
         step();
         if (i < TMO) chk("no_early_timeout", a_tmo, 1'b0);
      end
      chk("timeout_pulse", a_tmo, 1'b1);
      chk("timeout_idle", a_busy, 1'b0);
      chk("timeout_no_done", a_done, 1'b0);
      chk("timeout_frame_cnt", a_frame_cnt, 16'd1);
      step();
      chk("timeout_one_cycle", a_tmo, 1'b0);
      $display("frame timed out: frame_cnt=%0d", a_frame_cnt);

      // Abort at pixel 5
      a_start = 1'b1; step(); a_start = 1'b0;
      run_frame(0, 5, 1'b0);
      chk("abort_busy", a_busy, 1'b0);
      chk("abort_pix_val", a_pix_val, 1'b0);
      chk("abort_no_eof", a_pix_eof, 1'b0);
      chk("abort_rdy", a_src_rdy, 1'b0);
      chk("abort_frame_cnt", a_frame_cnt, 16'd1);
      step();
      chk("abort_no_done", {a_done, a_tmo}, 2'b00);

      // start and abort together in IDLE: abort wins
      a_start = 1'b1; a_abort = 1'b1; step(); a_start = 1'b0; a_abort = 1'b0;
      chk("start_abort_idle", a_busy, 1'b0);

      // Fresh frame after abort must begin with SOF at column 0
      a_start = 1'b1; step(); a_start = 1'b0;
      run_frame(30, -1, 1'b0);
      step(); step();
      a_canny = 1'b1; step(); a_canny = 1'b0;
      chk("post_abort_done", a_done, 1'b1);
      chk("post_abort_frame_cnt", a_frame_cnt, 16'd2);
      step();
      $display("frame done: frame_cnt=%0d", a_frame_cnt);

      // 1x1 frame: all four markers on one beat; start/canny_val in STREAM ignored
      b_start = 1'b1; step(); b_start = 1'b0;
      chk("b_stream_rdy", b_src_rdy, 1'b1);
      b_start = 1'b1; b_canny = 1'b1; b_src_val = 1'b1; b_src_data = 24'hABCDEF;
      step();
      b_start = 1'b0; b_canny = 1'b0; b_src_val = 1'b0;
      chk("b_pix_val", b_pix_val, 1'b1);
      chk("b_markers", {b_pix_sof, b_pix_eof, b_pix_sol, b_pix_eol}, 4'b1111);
      chk("b_pix_data", b_pix_data, 24'hABCDEF);
      chk("b_wait_rdy", b_src_rdy, 1'b0);
      chk("b_busy", b_busy, 1'b1);
      chk("b_canny_in_stream", b_frame_cnt, 16'd0);
      step();
      chk("b_single_beat", b_pix_val, 1'b0);
      b_canny = 1'b1; step(); b_canny = 1'b0;
      chk("b_done", b_done, 1'b1);
      chk("b_frame_cnt", b_frame_cnt, 16'd1);
      step();
      chk("b_idle", b_busy, 1'b0);
      $display("1x1 frame done: frame_cnt=%0d", b_frame_cnt);

      // Asynchronous reset in the middle of a frame
      a_start = 1'b1; step(); a_start = 1'b0;
      a_src_val = 1'b1; a_src_data = 24'h55AA55;
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", a_busy, 1'b0);
      chk("async_rst_pix", {a_pix_val, a_pix_sof, a_pix_eof, a_pix_sol, a_pix_eol}, 5'b0);
      chk("async_rst_frame_cnt", a_frame_cnt, 16'd0);
      a_src_val = 1'b0;
      #2 rst_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
